// File: rtl/cmd_dispatcher_pkg.sv
// ============================================================================
//  Module      : cmd_dispatcher_pkg
//  Description : Opcodes, FSM state encoding and helpers for cmd_dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_dispatcher_pkg;

   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_TRIGGER = 4'h1;
   localparam logic [3:0] OP_WRITE   = 4'h2;
   localparam logic [3:0] OP_READ    = 4'h3;
   localparam logic [3:0] OP_FORWARD = 4'h4;
   localparam logic [3:0] OP_SOFTRST = 4'hF;

   localparam logic [7:0] C_REPLY_HDR_DEFAULT = 8'hA5;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_DECODE     = 4'd1,
      S_PAYLOAD    = 4'd2,
      S_EXEC_WRITE = 4'd3,
      S_WAIT_TRIG  = 4'd4,
      S_TRIG       = 4'd5,
      S_FWD        = 4'd6,
      S_REPLY      = 4'd7,
      S_SOFTRST    = 4'd8
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_dispatcher_payload_shifter.sv
// ============================================================================
//  Module      : cmd_dispatcher_payload_shifter
//  Description : MSB-first payload collector with byte counter and idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_dispatcher_payload_shifter
   import cmd_dispatcher_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 2,
   parameter int TIMEOUT_W     = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       enable,
   input  logic                       byte_valid,
   input  logic [7:0]                 byte_in,
   output logic [PAYLOAD_BYTES*8-1:0] data,
   output logic [PAYLOAD_BYTES*8-1:0] data_next,
   output logic                       done,
   output logic                       timeout
);

   localparam int c_W     = PAYLOAD_BYTES * 8;
   localparam int c_CNT_W = $clog2(PAYLOAD_BYTES + 1);

   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_W-1:0]       r_shift;
   logic [TIMEOUT_W-1:0] r_to;

   generate
      if (PAYLOAD_BYTES == 1) begin : g_single
         assign data_next = byte_in;
      end else begin : g_multi
         assign data_next = {r_shift[c_W-9:0], byte_in};
      end
   endgenerate

   assign data    = r_shift;
   assign done    = enable && byte_valid && (r_cnt == c_CNT_W'(PAYLOAD_BYTES - 1));
   assign timeout = enable && (r_to == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_to    <= '0;
      end else if (clear) begin
         r_cnt   <= '0;
         r_shift <= '0;
         r_to    <= '0;
      end else if (enable) begin
         if (byte_valid) begin
            r_shift <= data_next;
            r_to    <= '0;
            r_cnt   <= done ? '0 : r_cnt + c_CNT_W'(1);
         end else if (!timeout) begin
            r_to <= r_to + TIMEOUT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cmd_dispatcher.sv
// ============================================================================
//  Module      : cmd_dispatcher
//  Description : Host command decoder: register write/read, triggers, forwards.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_dispatcher
   import cmd_dispatcher_pkg::*;
#(
   parameter int         PAYLOAD_BYTES = 2,
   parameter int         NUM_REGS      = 4,
   parameter int         NUM_TARGETS   = 4,
   parameter int         TIMEOUT_W     = 20,
   parameter logic [7:0] REPLY_HDR     = C_REPLY_HDR_DEFAULT
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [7:0]                          rx_rdata,
   input  logic                                rx_rempty,
   output logic                                rx_rinc,
   output logic [7:0]                          tx_wdata,
   output logic                                tx_winc,
   input  logic                                tx_wfull,
   output logic [NUM_TARGETS-1:0]              trig,
   input  logic [NUM_TARGETS-1:0]              trig_busy,
   output logic [PAYLOAD_BYTES*8-1:0]          fwd_data,
   output logic [NUM_TARGETS-1:0]              fwd_valid,
   input  logic [NUM_TARGETS-1:0]              fwd_ready,
   output logic [NUM_REGS*PAYLOAD_BYTES*8-1:0] regs,
   output logic                                soft_rst,
   output logic [7:0]                          err_count,
   output logic                                busy
);

   localparam int c_W      = PAYLOAD_BYTES * 8;
   localparam int c_RCNT_W = $clog2(PAYLOAD_BYTES + 2);

   state_t              r_state, w_next;
   logic                r_run;
   logic [7:0]          r_cmd;
   logic [7:0]          r_err;
   logic [c_W-1:0]      r_fwd_data;
   logic [c_W-1:0]      r_regs [NUM_REGS];
   logic [c_RCNT_W-1:0] r_rcnt;

   logic [3:0]             w_op, w_idx;
   logic                   w_reg_ok, w_tgt_ok, w_busy_sel;
   logic [NUM_TARGETS-1:0] w_tgt_onehot;
   logic [c_W-1:0]         w_rd_reg;
   logic [7:0]             w_tx_byte;
   logic                   w_cmd_load, w_err_inc, w_sh_clear, w_reg_we, w_fwd_load;
   logic                   w_sh_en, w_sh_take, w_done, w_timeout;
   logic [c_W-1:0]         w_sh_data, w_sh_next;

   assign w_op     = r_cmd[7:4];
   assign w_idx    = r_cmd[3:0];
   assign w_reg_ok = {1'b0, w_idx} < 5'(NUM_REGS);
   assign w_tgt_ok = {1'b0, w_idx} < 5'(NUM_TARGETS);

   always_comb begin
      w_tgt_onehot = '0;
      for (int t = 0; t < NUM_TARGETS; t++) begin
         w_tgt_onehot[t] = (w_idx == 4'(t));
      end
      w_busy_sel = |(trig_busy & w_tgt_onehot);
   end

   always_comb begin
      w_rd_reg = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (w_idx == 4'(r)) w_rd_reg = r_regs[r];
      end
   end

   // Reply byte order: header, echoed command, then register MSB first
   always_comb begin
      w_tx_byte = 8'h00;
      if (r_rcnt == '0) begin
         w_tx_byte = REPLY_HDR;
      end else if (r_rcnt == c_RCNT_W'(1)) begin
         w_tx_byte = r_cmd;
      end else begin
         for (int b = 0; b < PAYLOAD_BYTES; b++) begin
            if (r_rcnt == c_RCNT_W'(b + 2)) w_tx_byte = w_rd_reg[8*(PAYLOAD_BYTES-1-b) +: 8];
         end
      end
   end

   assign w_sh_en   = (r_state == S_PAYLOAD);
   assign w_sh_take = w_sh_en && !rx_rempty && !w_timeout;

   cmd_dispatcher_payload_shifter #(
      .PAYLOAD_BYTES (PAYLOAD_BYTES),
      .TIMEOUT_W     (TIMEOUT_W)
   ) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (w_sh_clear),
      .enable     (w_sh_en),
      .byte_valid (w_sh_take),
      .byte_in    (rx_rdata),
      .data       (w_sh_data),
      .data_next  (w_sh_next),
      .done       (w_done),
      .timeout    (w_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      rx_rinc    = 1'b0;
      tx_winc    = 1'b0;
      tx_wdata   = 8'h00;
      trig       = '0;
      fwd_valid  = '0;
      soft_rst   = 1'b0;
      w_cmd_load = 1'b0;
      w_err_inc  = 1'b0;
      w_sh_clear = 1'b0;
      w_reg_we   = 1'b0;
      w_fwd_load = 1'b0;
      case (r_state)
         S_IDLE: begin
            // r_run holds off popping until the first edge after reset release
            if (r_run && !rx_rempty) begin
               rx_rinc    = 1'b1;
               w_cmd_load = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            w_sh_clear = 1'b1;
            w_next     = S_IDLE;
            case (w_op)
               OP_NOP:     ;
               OP_WRITE:   if (w_reg_ok) w_next = S_PAYLOAD;   else w_err_inc = 1'b1;
               OP_FORWARD: if (w_tgt_ok) w_next = S_PAYLOAD;   else w_err_inc = 1'b1;
               OP_READ:    if (w_reg_ok) w_next = S_REPLY;     else w_err_inc = 1'b1;
               OP_TRIGGER: if (w_tgt_ok) w_next = S_WAIT_TRIG; else w_err_inc = 1'b1;
               OP_SOFTRST: w_next = S_SOFTRST;
               default:    w_err_inc = 1'b1;
            endcase
         end
         S_PAYLOAD: begin
            if (w_timeout) begin
               w_err_inc = 1'b1;
               w_next    = S_IDLE;
            end else if (w_sh_take) begin
               rx_rinc = 1'b1;
               if (w_done) begin
                  w_fwd_load = (w_op == OP_FORWARD);
                  w_next     = (w_op == OP_WRITE) ? S_EXEC_WRITE : S_FWD;
               end
            end
         end
         S_EXEC_WRITE: begin
            w_reg_we = 1'b1;
            w_next   = S_IDLE;
         end
         S_WAIT_TRIG: begin
            if (!w_busy_sel) w_next = S_TRIG;
         end
         S_TRIG: begin
            trig   = w_tgt_onehot;
            w_next = S_IDLE;
         end
         S_FWD: begin
            fwd_valid = w_tgt_onehot;
            if (|(fwd_ready & w_tgt_onehot)) w_next = S_IDLE;
         end
         S_REPLY: begin
            tx_wdata = w_tx_byte;
            if (!tx_wfull) begin
               tx_winc = 1'b1;
               if (r_rcnt == c_RCNT_W'(PAYLOAD_BYTES + 1)) w_next = S_IDLE;
            end
         end
         S_SOFTRST: begin
            soft_rst = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run      <= 1'b0;
         r_cmd      <= 8'h00;
         r_err      <= 8'h00;
         r_fwd_data <= '0;
         r_rcnt     <= '0;
         for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
      end else begin
         r_run <= 1'b1;
         if (w_cmd_load) r_cmd <= rx_rdata;
         if (w_err_inc)  r_err <= sat_inc8(r_err);
         if (w_fwd_load) r_fwd_data <= w_sh_next;
         if (w_sh_clear)   r_rcnt <= '0;
         else if (tx_winc) r_rcnt <= r_rcnt + c_RCNT_W'(1);
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_reg_we && (w_idx == 4'(r))) r_regs[r] <= w_sh_data;
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
         assign regs[g*c_W +: c_W] = r_regs[g];
      end
   endgenerate

   assign fwd_data  = r_fwd_data;
   assign err_count = r_err;
   assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
